// File: rtl/mem_write_arbiter_if.sv
// rtl/mem_write_arbiter_if.sv - requester, clear and memory-port bundle for the write arbiter
interface mem_write_arbiter_if #(
   parameter int A = 9,
   parameter int S = 24
) ();
   logic         req0;
   logic         req1;
   logic [A-1:0] addr0;
   logic [A-1:0] addr1;
   logic [S-1:0] data0;
   logic [S-1:0] data1;
   logic         ack0;
   logic         ack1;
   logic         clear_req;
   logic         clear_done;
   logic [A-1:0] mem_address;
   logic [S-1:0] mem_data;
   logic         mem_wren;
   logic         mem_clear;
   logic         busy;

   modport master (
      output req0, req1, addr0, addr1, data0, data1, clear_req,
      input  ack0, ack1, clear_done, mem_address, mem_data, mem_wren, mem_clear, busy
   );

   modport slave (
      input  req0, req1, addr0, addr1, data0, data1, clear_req,
      output ack0, ack1, clear_done, mem_address, mem_data, mem_wren, mem_clear, busy
   );
endinterface

// File: rtl/mem_write_arbiter.sv
// rtl/mem_write_arbiter.sv - two-requester round-robin memory write arbiter with priority clear
module mem_write_arbiter #(
   parameter int A = 9,
   parameter int S = 24
) (
   input logic                i_clk,
   input logic                i_rst_n,
   mem_write_arbiter_if.slave i_bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CLEAR = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t       r_state;
   logic         r_last_grant;
   logic         r_ack0;
   logic         r_ack1;
   logic         r_clear_done;
   logic         r_mem_wren;
   logic         r_mem_clear;
   logic         r_busy;
   logic [A-1:0] r_mem_address;
   logic [S-1:0] r_mem_data;

   logic w_elig0;
   logic w_elig1;
   logic w_clr_elig;
   logic w_grant;

   // A requester acked this cycle is still holding req; it must not be regranted.
   assign w_elig0    = i_bus.req0 & ~r_ack0;
   assign w_elig1    = i_bus.req1 & ~r_ack1;
   assign w_clr_elig = i_bus.clear_req & ~r_clear_done;
   assign w_grant    = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_last_grant  <= 1'b1;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_clear_done  <= 1'b0;
         r_mem_wren    <= 1'b0;
         r_mem_clear   <= 1'b0;
         r_busy        <= 1'b0;
         r_mem_address <= '0;
         r_mem_data    <= '0;
      end else begin
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_clear_done <= 1'b0;
         r_mem_wren   <= 1'b0;
         r_mem_clear  <= 1'b0;
         case (r_state)
            ST_CLEAR: begin
               r_state      <= ST_DONE;
               r_clear_done <= 1'b1;
               r_busy       <= 1'b1;
            end
            default: begin
               if (w_clr_elig) begin
                  r_state     <= ST_CLEAR;
                  r_mem_clear <= 1'b1;
                  r_busy      <= 1'b1;
               end else if (w_elig0 | w_elig1) begin
                  r_state      <= ST_WRITE;
                  r_mem_wren   <= 1'b1;
                  r_busy       <= 1'b1;
                  r_last_grant <= w_grant;
                  if (w_grant) begin
                     r_ack1        <= 1'b1;
                     r_mem_address <= i_bus.addr1;
                     r_mem_data    <= i_bus.data1;
                  end else begin
                     r_ack0        <= 1'b1;
                     r_mem_address <= i_bus.addr0;
                     r_mem_data    <= i_bus.data0;
                  end
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign i_bus.ack0        = r_ack0;
   assign i_bus.ack1        = r_ack1;
   assign i_bus.clear_done  = r_clear_done;
   assign i_bus.mem_wren    = r_mem_wren;
   assign i_bus.mem_clear   = r_mem_clear;
   assign i_bus.busy        = r_busy;
   assign i_bus.mem_address = r_mem_address;
   assign i_bus.mem_data    = r_mem_data;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb/tb_mem_write_arbiter.sv - directed self-checking bench for mem_write_arbiter
module tb_mem_write_arbiter;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   mem_write_arbiter_if #(.A(9), .S(24)) bus ();

   mem_write_arbiter #(.A(9), .S(24)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_pulses(input string tag, input logic a0, input logic a1, input logic wr,
                               input logic clr, input logic done, input logic bsy);
      check({tag, " ack0"}, {31'd0, bus.ack0}, {31'd0, a0});
      check({tag, " ack1"}, {31'd0, bus.ack1}, {31'd0, a1});
      check({tag, " mem_wren"}, {31'd0, bus.mem_wren}, {31'd0, wr});
      check({tag, " mem_clear"}, {31'd0, bus.mem_clear}, {31'd0, clr});
      check({tag, " clear_done"}, {31'd0, bus.clear_done}, {31'd0, done});
      check({tag, " busy"}, {31'd0, bus.busy}, {31'd0, bsy});
   endtask

   task automatic check_mem(input string tag, input logic [8:0] adr, input logic [23:0] dat);
      check({tag, " mem_address"}, {23'd0, bus.mem_address}, {23'd0, adr});
      check({tag, " mem_data"}, {8'd0, bus.mem_data}, {8'd0, dat});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.addr0 = '0;
      bus.addr1 = '0;
      bus.data0 = '0;
      bus.data1 = '0;
      bus.clear_req = 1'b0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      check_pulses("reset", 0, 0, 0, 0, 0, 0);
      check_mem("reset", 9'h000, 24'h000000);

      // Single write right after reset release
      rst_n = 1'b1;
      bus.req0 = 1'b1;
      bus.addr0 = 9'h005;
      bus.data0 = 24'hABCDEF;
      @(negedge clk);
      check_pulses("single_w", 1, 0, 1, 0, 0, 1);
      check_mem("single_w", 9'h005, 24'hABCDEF);
      bus.req0 = 1'b0;
      @(negedge clk);
      check_pulses("single_idle", 0, 0, 0, 0, 0, 0);
      check_mem("single_hold", 9'h005, 24'hABCDEF);

      // Both requesters from reset release alternate 0,1,0,1
      rst_n = 1'b0;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      bus.addr0 = 9'h011;
      bus.data0 = 24'h111111;
      bus.addr1 = 9'h022;
      bus.data1 = 24'h222222;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            check_pulses($sformatf("rr%0d", i), 1, 0, 1, 0, 0, 1);
            check_mem($sformatf("rr%0d", i), 9'h011, 24'h111111);
         end else begin
            check_pulses($sformatf("rr%0d", i), 0, 1, 1, 0, 0, 1);
            check_mem($sformatf("rr%0d", i), 9'h022, 24'h222222);
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      check_pulses("rr_idle", 0, 0, 0, 0, 0, 0);

      // Lone requester 1 gets a write every other cycle
      bus.req1 = 1'b1;
      bus.addr1 = 9'h1FF;
      bus.data1 = 24'hFFFFFF;
      for (int i = 2; i <= 7; i++) begin
         @(negedge clk);
         check_pulses($sformatf("solo1_c%0d", i), 0, (i % 2 == 0), (i % 2 == 0), 0, 0, (i % 2 == 0));
      end
      check_mem("solo1", 9'h1FF, 24'hFFFFFF);
      bus.req1 = 1'b0;
      @(negedge clk);

      // Tie after requester 0 was last granted goes to requester 1
      bus.req0 = 1'b1;
      bus.addr0 = 9'h0A0;
      bus.data0 = 24'h00A0A0;
      @(negedge clk);
      check_pulses("pre_tie", 1, 0, 1, 0, 0, 1);
      bus.req0 = 1'b0;
      @(negedge clk);
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      @(negedge clk);
      check_pulses("tie_last0", 0, 1, 1, 0, 0, 1);
      check_mem("tie_last0", 9'h1FF, 24'hFFFFFF);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);

      // Clear has priority over a simultaneous write
      bus.clear_req = 1'b1;
      bus.req0 = 1'b1;
      @(negedge clk);
      check_pulses("clr_c1", 0, 0, 0, 1, 0, 1);
      @(negedge clk);
      check_pulses("clr_c2", 0, 0, 0, 0, 1, 1);
      bus.clear_req = 1'b0;
      @(negedge clk);
      check_pulses("clr_c3", 1, 0, 1, 0, 0, 1);
      check_mem("clr_c3", 9'h0A0, 24'h00A0A0);
      bus.req0 = 1'b0;
      @(negedge clk);
      check_pulses("clr_idle", 0, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a write
      bus.req0 = 1'b1;
      @(negedge clk);
      check_pulses("pre_rst_w", 1, 0, 1, 0, 0, 1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b1;
      rst_n = 1'b0;
      #1;
      check_pulses("async_rst", 0, 0, 0, 0, 0, 0);
      check_mem("async_rst", 9'h000, 24'h000000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_pulses("post_rst", 0, 1, 1, 0, 0, 1);
      check_mem("post_rst", 9'h1FF, 24'hFFFFFF);
      bus.req1 = 1'b0;
      @(negedge clk);
      check_pulses("post_rst_idle", 0, 0, 0, 0, 0, 0);

      // Held clear: CLEAR, DONE, IDLE, CLEAR, DONE
      bus.clear_req = 1'b1;
      @(negedge clk);
      check_pulses("bb_c1", 0, 0, 0, 1, 0, 1);
      @(negedge clk);
      check_pulses("bb_c2", 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      check_pulses("bb_c3", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_pulses("bb_c4", 0, 0, 0, 1, 0, 1);
      @(negedge clk);
      check_pulses("bb_c5", 0, 0, 0, 0, 1, 1);
      bus.clear_req = 1'b0;
      @(negedge clk);
      check_pulses("bb_idle", 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
